// File: rtl/seg7_scan.sv
// ============================================================================
// Module   : seg7_scan
// Brief    : Four-digit multiplexed seven-segment driver with per-frame input
//            snapshot, per-slot blanking and active-low hex decode.
//            Optional macro SEG7_LEADING_ZERO_BLANK_EN hides leading zeros.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] arr0,
    input  logic [3:0] arr1,
    input  logic [3:0] arr2,
    input  logic [3:0] arr3,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        r_dig;
    logic [1:0]        w_dig_nxt;
    logic [19:0]       r_snap;
    logic [19:0]       w_snap_nxt;
    logic              w_load;
    logic [3:0]        w_nib;
    logic [3:0]        w_snap_dp;
    logic              w_lz_hide;
    logic [3:0]        w_an_nxt;
    logic [6:0]        w_seg_nxt;
    logic              w_dp_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The IDLE state makes the first edge after reset release behave like a
    // frame wrap: it enters slot 0 of digit 0 and takes the snapshot.
    always_comb begin
        w_load    = 1'b0;
        w_cnt_nxt = r_cnt + 1'b1;
        w_dig_nxt = r_dig;
        if (r_state == ST_IDLE) begin
            w_cnt_nxt = '0;
            w_dig_nxt = 2'd0;
            w_load    = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            w_dig_nxt = r_dig + 2'd1;
            w_load    = (r_dig == 2'd3);
        end
        w_state_nxt = (w_cnt_nxt < BLANK_END) ? ST_BLANK : ST_SHOW;
        w_snap_nxt  = w_load ? {dp_mask, arr3, arr2, arr1, arr0} : r_snap;
    end

    assign w_nib     = w_snap_nxt[{w_dig_nxt, 2'b00} +: 4];
    assign w_snap_dp = w_snap_nxt[19:16];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Hide digit k when it and every digit to its left are zero, unless the
    // decimal point is requested on that digit.
    always_comb begin
        w_lz_hide = 1'b0;
        case (w_dig_nxt)
            2'd3:    w_lz_hide = (w_snap_nxt[15:12] == 4'h0);
            2'd2:    w_lz_hide = (w_snap_nxt[15:8]  == 8'h00);
            2'd1:    w_lz_hide = (w_snap_nxt[15:4]  == 12'h000);
            default: w_lz_hide = 1'b0;
        endcase
        if (w_snap_dp[w_dig_nxt])
            w_lz_hide = 1'b0;
    end
`else
    assign w_lz_hide = 1'b0;
`endif

    // Outputs are decoded from next-state values so they land on the same
    // edge as the counters they describe.
    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if ((w_state_nxt == ST_SHOW) && !w_lz_hide) begin
            w_an_nxt  = ~(4'b0001 << w_dig_nxt);
            w_seg_nxt = hex7(w_nib);
            w_dp_nxt  = ~w_snap_dp[w_dig_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_dig      <= 2'd0;
            r_snap     <= '0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dig      <= w_dig_nxt;
            r_snap     <= w_snap_nxt;
            an         <= w_an_nxt;
            seg        <= w_seg_nxt;
            dp         <= w_dp_nxt;
            frame_tick <= w_load;
        end
    end

endmodule

`default_nettype wire
